// File: rtl/fadd_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe_if
// Purpose  : Issue/result handshake bundle for the pipelined FP adder.
// Revision : 1.0 - initial release
// ============================================================================
interface fadd_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic             sub;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag_out;
    logic [2:0]       flags;

    modport master (
        output in_valid, x1, x2, sub, tag_in, out_ready,
        input  in_ready, out_valid, y, tag_out, flags
    );

    modport slave (
        input  in_valid, x1, x2, sub, tag_in, out_ready,
        output in_ready, out_valid, y, tag_out, flags
    );
endinterface
`default_nettype wire

// File: rtl/fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fadd_pipe
// Purpose  : Pipelined IEEE-754 add/subtract, RNE rounding, valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int PIPE  = 3,
    parameter int TAG_W = 5
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    fadd_pipe_if.slave      bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;          // {hidden, man, G, R, S}
    localparam int SW = MAN_W + 3;          // alignment shift saturation
    localparam logic [EXP_W-1:0] C_EXP_ONES = '1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic [W-1:0]     spec_y;
        logic             spec_inv;
        logic             sign;
        logic             zsign;
        logic             eff_sub;
        logic [EXP_W:0]   exp;
        logic [MW-1:0]    mb;
        logic [MW-1:0]    ms;
    } align_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic [W-1:0]     spec_y;
        logic             spec_inv;
        logic             sign;
        logic [EXP_W:0]   exp;
        logic [MW-1:0]    m;
    } norm_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     y;
        logic [2:0]       flags;
    } out_t;

    align_t w_a, w_aq;
    norm_t  w_n, w_nq;
    out_t   w_o, w_fin, r_o;
    logic   w_adv;

    assign w_adv         = !w_fin.valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = w_fin.valid;
    assign bus.y         = w_fin.y;
    assign bus.tag_out   = w_fin.tag;
    assign bus.flags     = w_fin.flags;

    // ---------------------------------------------------------------- align
    logic             w_s1, w_s2, w_s2e;
    logic [EXP_W-1:0] w_e1, w_e2, w_ee1, w_ee2, w_eb, w_es, w_diff;
    logic [MAN_W-1:0] w_m1, w_m2, w_mbig, w_msml;
    logic             w_h1, w_h2, w_hb, w_hs;
    logic             w_nan1, w_nan2, w_inf1, w_inf2, w_snan;
    logic             w_x1_big;
    logic [31:0]      w_shamt;
    logic [2*SW-1:0]  w_sh_in, w_sh_out;

    assign w_s1   = bus.x1[W-1];
    assign w_s2   = bus.x2[W-1];
    assign w_s2e  = w_s2 ^ bus.sub;
    assign w_e1   = bus.x1[W-2:MAN_W];
    assign w_e2   = bus.x2[W-2:MAN_W];
    assign w_m1   = bus.x1[MAN_W-1:0];
    assign w_m2   = bus.x2[MAN_W-1:0];
    assign w_h1   = (w_e1 != '0);
    assign w_h2   = (w_e2 != '0);
    assign w_ee1  = w_h1 ? w_e1 : EXP_W'(1);
    assign w_ee2  = w_h2 ? w_e2 : EXP_W'(1);
    assign w_nan1 = (w_e1 == C_EXP_ONES) && (w_m1 != '0);
    assign w_nan2 = (w_e2 == C_EXP_ONES) && (w_m2 != '0);
    assign w_inf1 = (w_e1 == C_EXP_ONES) && (w_m1 == '0);
    assign w_inf2 = (w_e2 == C_EXP_ONES) && (w_m2 == '0);
    assign w_snan = (w_nan1 && !w_m1[MAN_W-1]) || (w_nan2 && !w_m2[MAN_W-1]);

    assign w_x1_big = {w_e1, w_m1} >= {w_e2, w_m2};
    assign w_eb     = w_x1_big ? w_ee1 : w_ee2;
    assign w_es     = w_x1_big ? w_ee2 : w_ee1;
    assign w_hb     = w_x1_big ? w_h1  : w_h2;
    assign w_hs     = w_x1_big ? w_h2  : w_h1;
    assign w_mbig   = w_x1_big ? w_m1  : w_m2;
    assign w_msml   = w_x1_big ? w_m2  : w_m1;
    assign w_diff   = w_eb - w_es;
    assign w_shamt  = (32'(w_diff) > 32'(SW)) ? 32'(SW) : 32'(w_diff);
    // Bits shifted into the lower half are collapsed into the sticky bit.
    assign w_sh_in  = {w_hs, w_msml, 2'b00, {SW{1'b0}}};
    assign w_sh_out = w_sh_in >> w_shamt;

    always_comb begin
        w_a          = '0;
        w_a.valid    = bus.in_valid;
        w_a.tag      = bus.tag_in;
        w_a.sign     = w_x1_big ? w_s1 : w_s2e;
        w_a.zsign    = w_s1 & w_s2e;
        w_a.eff_sub  = w_s1 ^ w_s2e;
        w_a.exp      = {1'b0, w_eb};
        w_a.mb       = {w_hb, w_mbig, 3'b000};
        w_a.ms       = {w_sh_out[2*SW-1:SW], |w_sh_out[SW-1:0]};
        w_a.spec_inv = w_snan;
        if (w_nan1) begin
            w_a.spec   = 1'b1;
            w_a.spec_y = {w_s1, C_EXP_ONES, 1'b1, w_m1[MAN_W-2:0]};
        end else if (w_nan2) begin
            w_a.spec   = 1'b1;
            w_a.spec_y = {w_s2, C_EXP_ONES, 1'b1, w_m2[MAN_W-2:0]};
        end else if (w_inf1 && w_inf2 && (w_s1 != w_s2e)) begin
            w_a.spec     = 1'b1;
            w_a.spec_inv = 1'b1;
            w_a.spec_y   = {1'b1, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_inf1) begin
            w_a.spec   = 1'b1;
            w_a.spec_y = {w_s1, C_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_inf2) begin
            w_a.spec   = 1'b1;
            w_a.spec_y = {w_s2e, C_EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    generate
        if (PIPE >= 3) begin : g_s1_reg
            align_t r_a;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)      r_a <= '0;
                else if (w_adv) r_a <= w_a;
            end
            assign w_aq = r_a;
        end else begin : g_s1_comb
            assign w_aq = w_a;
        end
    endgenerate

    // ------------------------------------------------------ add + normalise
    logic [MW:0]  w_sum;
    logic [31:0]  w_lzc, w_lim, w_nsh;

    assign w_sum = w_aq.eff_sub ? ({1'b0, w_aq.mb} - {1'b0, w_aq.ms})
                                : ({1'b0, w_aq.mb} + {1'b0, w_aq.ms});

    always_comb begin
        w_lzc = 32'(MW);
        for (int i = 0; i < MW; i++) begin
            if (w_sum[i]) w_lzc = 32'(MW - 1 - i);
        end
    end

    // Left shift stops at exponent 1 so tiny results fall out as subnormals.
    assign w_lim = 32'(w_aq.exp) - 32'd1;
    assign w_nsh = (w_lzc < w_lim) ? w_lzc : w_lim;

    always_comb begin
        w_n          = '0;
        w_n.valid    = w_aq.valid;
        w_n.tag      = w_aq.tag;
        w_n.spec     = w_aq.spec;
        w_n.spec_y   = w_aq.spec_y;
        w_n.spec_inv = w_aq.spec_inv;
        w_n.sign     = (w_sum == '0) ? w_aq.zsign : w_aq.sign;
        if (w_sum[MW]) begin
            w_n.m   = {w_sum[MW:2], w_sum[1] | w_sum[0]};
            w_n.exp = w_aq.exp + 1'b1;
        end else begin
            w_n.m   = w_sum[MW-1:0] << w_nsh;
            w_n.exp = w_aq.exp - (EXP_W+1)'(w_nsh);
        end
    end

    generate
        if (PIPE >= 2) begin : g_s2_reg
            norm_t r_n;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)      r_n <= '0;
                else if (w_adv) r_n <= w_n;
            end
            assign w_nq = r_n;
        end else begin : g_s2_comb
            assign w_nq = w_n;
        end
    endgenerate

    // -------------------------------------------------------- round + pack
    logic             w_g, w_r, w_st, w_lsb, w_up, w_inexact, w_ovf, w_rh;
    logic [MAN_W+1:0] w_rm;
    logic [EXP_W:0]   w_rexp;
    logic [MAN_W-1:0] w_rman;

    assign w_lsb     = w_nq.m[3];
    assign w_g       = w_nq.m[2];
    assign w_r       = w_nq.m[1];
    assign w_st      = w_nq.m[0];
    assign w_up      = w_g && (w_r || w_st || w_lsb);
    assign w_inexact = w_g | w_r | w_st;
    assign w_rm      = {1'b0, w_nq.m[MW-1:3]} + (MAN_W+2)'(w_up);
    assign w_rexp    = w_rm[MAN_W+1] ? (w_nq.exp + 1'b1) : w_nq.exp;
    assign w_rman    = w_rm[MAN_W+1] ? w_rm[MAN_W:1] : w_rm[MAN_W-1:0];
    assign w_rh      = w_rm[MAN_W+1] | w_rm[MAN_W];
    assign w_ovf     = (w_rexp >= {1'b0, C_EXP_ONES});

    always_comb begin
        w_o       = '0;
        w_o.valid = w_nq.valid;
        w_o.tag   = w_nq.tag;
        if (w_nq.spec) begin
            w_o.y     = w_nq.spec_y;
            w_o.flags = {w_nq.spec_inv, 2'b00};
        end else if (w_ovf) begin
            w_o.y     = {w_nq.sign, C_EXP_ONES, {MAN_W{1'b0}}};
            w_o.flags = 3'b011;
        end else begin
            w_o.y     = {w_nq.sign, (w_rh ? w_rexp[EXP_W-1:0] : {EXP_W{1'b0}}), w_rman};
            w_o.flags = {2'b00, w_inexact};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_o <= '0;
        else if (w_adv) r_o <= w_o;
    end

    generate
        if (PIPE >= 4) begin : g_out_reg
            out_t r_o2;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)      r_o2 <= '0;
                else if (w_adv) r_o2 <= r_o;
            end
            assign w_fin = r_o2;
        end else begin : g_out_direct
            assign w_fin = r_o;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_fadd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_pipe
// Purpose  : Scoreboard bench for fadd_pipe (binary32, PIPE=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fadd_pipe;
    localparam int NV = 19;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic        sub;
        logic [31:0] y;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        logic [2:0]  fl;
        int          acc;
        bit          lat;
    } sb_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   g_lat    = 1'b0;
    sb_t  q[$];
    vec_t vec[NV];

    fadd_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) bus ();

    fadd_pipe #(.EXP_W(8), .MAN_W(23), .PIPE(3), .TAG_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive on the falling edge, observe 1 time unit later.
    task automatic cycle(input logic iv, input int vi, input logic [4:0] tg,
                         input logic ordy, output logic acc);
        sb_t e;
        @(negedge clk);
        cyc++;
        bus.in_valid  = iv;
        bus.x1        = vec[vi].x1;
        bus.x2        = vec[vi].x2;
        bus.sub       = vec[vi].sub;
        bus.tag_in    = tg;
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = q[0];
                check_eq("y",       64'(bus.y),       64'(e.y));
                check_eq("tag_out", 64'(bus.tag_out), 64'(e.tag));
                check_eq("flags",   64'(bus.flags),   64'(e.fl));
                if (ordy) begin
                    if (e.lat) check_eq("latency", 64'(cyc - e.acc), 64'd3);
                    void'(q.pop_front());
                end
            end
        end
        if (acc) begin
            e.y   = vec[vi].y;
            e.tag = tg;
            e.fl  = vec[vi].fl;
            e.acc = cyc;
            e.lat = g_lat;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while (q.size() > 0 && n < 50) begin
            cycle(1'b0, 0, 5'd0, 1'b1, a);
            n++;
        end
        check_eq("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic a;
        int   i;
        vec = '{
            '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},
            '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
            '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
            '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001},
            '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001},
            '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011},
            '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000},
            '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000},
            '{32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 3'b100},
            '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FE00000, 3'b100},
            '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000},
            '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000},
            '{32'h3F800000, 32'hFFA00000, 1'b0, 32'hFFE00000, 3'b100},
            '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000},
            '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000},
            '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000},
            '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000},
            '{32'h7FC00001, 32'h7F800000, 1'b0, 32'h7FC00001, 3'b000},
            '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000, 3'b000}
        };
        bus.in_valid  = 1'b0;
        bus.x1        = '0;
        bus.x2        = '0;
        bus.sub       = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_y",         64'(bus.y),         64'd0);
        check_eq("rst_tag_out",   64'(bus.tag_out),   64'd0);
        check_eq("rst_flags",     64'(bus.flags),     64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single op with latency check
        g_lat = 1'b1;
        cycle(1'b1, 0, 5'd3, 1'b1, a);
        check_eq("accept_first", 64'(a), 64'd1);
        drain();

        // Every vector back to back
        for (int k = 0; k < NV; k++) cycle(1'b1, k, 5'(k), 1'b1, a);
        drain();

        // Backpressure: 6 ops, out_ready low for 4 cycles mid-stream
        g_lat = 1'b0;
        i = 0;
        for (int k = 0; k < 40 && i < 6; k++) begin
            logic st;
            st = (k >= 4 && k < 8);
            cycle(1'b1, i + 3, 5'(i), !st, a);
            if (st && k > 4) check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (a) i++;
        end
        check_eq("bp_all_issued", 64'(i), 64'd6);
        drain();

        // Reset mid-stream discards in-flight ops
        for (int k = 0; k < 4; k++) cycle(1'b1, k + 10, 5'(k + 20), 1'b1, a);
        @(negedge clk);
        cyc++;
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_flags",     64'(bus.flags),     64'd0);
        q.delete();
        @(negedge clk);
        cyc++;
        rstn = 1'b1;
        g_lat = 1'b1;
        cycle(1'b1, 13, 5'd9, 1'b1, a);
        check_eq("post_rst_accept", 64'(a), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor. It is the successor of the team's single-cycle fadd and is generalised in exponent and mantissa width, pipeline depth and operation mode. It adds a full valid/ready handshake with backpressure, a tag passthrough and exception flags. It sits between the FPU issue logic and the writeback arbiter.

Parameters:
EXP_W, 8, exponent field width (≥4)
MAN_W, 23, stored mantissa width (≥4)
PIPE, 3, pipeline stages from input accept to output (1..4); stage split is align / add+normalise / round+pack, merged left-to-right when PIPE<3, extra register on output when PIPE=4
TAG_W, 5, width of opaque tag carried alongside the operation

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operands presented
in_ready  out  1  block can accept this cycle
x1  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
x2  in  1+EXP_W+MAN_W  operand B
sub  in  1  0: y=x1+x2, 1: y=x1−x2 (sign of x2 inverted before processing)
tag_in  in  TAG_W  tag captured with operands
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
y  out  1+EXP_W+MAN_W  result
tag_out  out  TAG_W  tag of result
flags  out  3  {invalid, overflow, inexact}

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. All stage valid bits, out_valid, y, tag_out and flags reset to 0.
- Advance condition adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0. in_ready = adv (combinational from out_ready and out_valid).
- Accept occurs when in_valid && in_ready. A bubble enters when in_valid=0 and adv=1.
- Latency is exactly PIPE cycles from accept to out_valid when out_ready is held 1. Throughput is 1 op/cycle. No reordering.
- y, tag_out and flags stay stable while out_valid && !out_ready.
- Assertion of rstn mid-operation discards all in-flight ops. out_valid falls immediately.
- Operand decode:
  - exp=0 is subnormal: hidden bit 0, effective exp 1.
  - exp=all-ones with man≠0 is NaN; with man=0 it is Inf.
- Align:
  - The larger-magnitude operand is selected by comparing {exp, man}. On equal magnitudes, x1 is selected.
  - The smaller operand is right-shifted by the exponent difference, saturated at MAN_W+3.
  - Guard and round bits are kept, and all shifted-out bits are ORed into sticky.
- Add/subtract:
  - Effective subtract when the signs differ (after the sub inversion).
  - Carry-out gives a 1-bit right shift with exp+1, folding the LSB into sticky.
- Normalise: leading-zero count, left shift limited so the exponent does not drop below 1. A result left with exp 1 and no hidden bit packs as subnormal (exp field 0).
- Rounding:
  - Round-to-nearest-even only: round up iff G && (R || S || LSB).
  - Mantissa carry-out after rounding increments the exponent.
  - inexact = G|R|S before rounding.
- Overflow: exponent reaching all-ones gives ±Inf and sets overflow and inexact.
- Exact zero result: sign = s1 & s2_eff, so −0 + −0 = −0 and x − x = +0.
- Special results, in priority order:
  - x1 NaN gives x1 quieted (man MSB forced 1, payload kept).
  - Otherwise x2 NaN gives x2 quieted (sign of the original x2).
  - Inf − Inf (effective) gives canonical NaN {1, all-ones, 1, 0…} with invalid=1.
  - Single Inf gives that Inf with sub-adjusted sign.
  - Inf + Inf with the same sign gives that Inf.
  - NaN and Inf results raise no overflow or inexact. Signalling NaN input sets invalid=1.
- flags are per-result, not sticky, and cleared on reset.

Test Plan:
1. Default params, out_ready=1: x1=0x3F800000, x2=0x40000000, sub=0, tag=3 → after 3 cycles y=0x40400000, tag_out=3, flags=000.
2. x1=x2=0x3F800000, sub=1 → y=0x00000000 (+0). Then x1=x2=0x80000000, sub=0 → y=0x80000000.
3. Rounding: 0x3F800000+0x33800000 → 0x3F800000 with inexact=1 (tie to even). 0x3F800000+0x33800001 → 0x3F800001 with inexact=1.
4. Overflow/subnormal:
   - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 with flags=011.
   - 0x00000001+0x00000001 → 0x00000002 with flags=000.
   - 0x00800000 − 0x00000001 → 0x007FFFFF.
5. Specials:
   - 0x7F800000 − 0x7F800000 → 0xFFC00000 with invalid=1.
   - 0x7FA00000+0x3F800000 → 0x7FE00000 with invalid=1.
   - 0xFF800000+0x3F800000 → 0xFF800000.
6. Backpressure: issue 6 back-to-back ops with tags 0..5 and hold out_ready=0 for 4 cycles mid-stream.
   - in_ready drops.
   - No op is lost or duplicated, tags emerge in order, and y is stable during the stall.
   - Pulsing rstn low mid-stream clears out_valid at once, and the next accepted op completes normally.
